// File: rtl/tinymips_pkg.sv
// Shared definitions for the tinymips execute-side datapath.
//   ALU operation codes, the bubble ALU code loaded on flush/reset,
//   and the operand forwarding select encoding.
package tinymips_pkg;

    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b110;
    // A bubble carries an ADD so the ALU sees a harmless, well-defined op.
    localparam logic [2:0] ALU_BUBBLE = ALU_ADD;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux: picks the freshest value of one source register.
//   src_reg        : registered source register number
//   reg_data       : registered register-file read data
//   mem_* / wb_*   : destination info from the memory and writeback stages
//   fwd_data       : forwarded operand value
// The memory stage holds the younger result, so it wins over writeback.
// Register 0 is hardwired to zero and is never forwarded.
module fwd_mux
    import tinymips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       src_reg,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_write_reg,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] fwd_data
);

    fwd_sel_e fwd_sel;

    always_comb begin
        fwd_sel = FWD_REG;
        if (src_reg != 5'd0) begin
            if (mem_reg_write && (mem_write_reg == src_reg))
                fwd_sel = FWD_MEM;
            else if (wb_reg_write && (wb_write_reg == src_reg))
                fwd_sel = FWD_WB;
        end
    end

    always_comb begin
        case (fwd_sel)
            FWD_MEM: fwd_data = mem_alu_result;
            FWD_WB:  fwd_data = wb_result;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register plus operand forwarding.
//   clk, reset_n        : clock, asynchronous active-low reset
//   stall, flush        : hold the stage / load a bubble (flush wins)
//   id_*                : decoded instruction fields captured each edge
//   mem_*, wb_*         : downstream results used for forwarding
//   ex_valid            : execute-stage instruction valid
//   srca, srcb          : ALU operands (srcb may be the sign-extended imm)
//   alu_control         : ALU operation code
//   ex_write_data       : forwarded rt value, used as store data
//   ex_reg_write/_reg   : destination passed downstream
// Forwarding is combinational off the registered rs/rt, so a stalled
// instruction keeps picking up results as they move through mem/wb.
module alu_operand_stage
    import tinymips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [15:0]      id_imm,
    input  logic             id_alu_src,
    input  logic [2:0]       id_alu_control,
    input  logic             id_reg_write,
    input  logic [4:0]       id_write_reg,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_write_reg,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic [WIDTH-1:0] wb_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] srca,
    output logic [WIDTH-1:0] srcb,
    output logic [2:0]       alu_control,
    output logic [WIDTH-1:0] ex_write_data,
    output logic             ex_reg_write,
    output logic [4:0]       ex_write_reg
);

    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [15:0]      imm_q;
    logic             alu_src_q;
    logic [WIDTH-1:0] imm_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_write_reg <= 5'd0;
            alu_control  <= ALU_BUBBLE;
            rd1_q        <= '0;
            rd2_q        <= '0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            imm_q        <= 16'd0;
            alu_src_q    <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_write_reg <= 5'd0;
            alu_control  <= ALU_BUBBLE;
            rd1_q        <= '0;
            rd2_q        <= '0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            imm_q        <= 16'd0;
            alu_src_q    <= 1'b0;
        end else if (!stall) begin
            // An invalid slot still carries its fields but must not write back.
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid & id_reg_write;
            ex_write_reg <= id_write_reg;
            alu_control  <= id_alu_control;
            rd1_q        <= id_rd1;
            rd2_q        <= id_rd2;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            imm_q        <= id_imm;
            alu_src_q    <= id_alu_src;
        end
    end

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
        .src_reg        (rs_q),
        .reg_data       (rd1_q),
        .mem_reg_write  (mem_reg_write),
        .mem_write_reg  (mem_write_reg),
        .mem_alu_result (mem_alu_result),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_result      (wb_result),
        .fwd_data       (srca)
    );

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
        .src_reg        (rt_q),
        .reg_data       (rd2_q),
        .mem_reg_write  (mem_reg_write),
        .mem_write_reg  (mem_write_reg),
        .mem_alu_result (mem_alu_result),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_result      (wb_result),
        .fwd_data       (ex_write_data)
    );

    assign imm_ext = {{(WIDTH-16){imm_q[15]}}, imm_q};
    assign srcb    = alu_src_q ? imm_ext : ex_write_data;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a vector table for single-edge
// behaviour plus hand sequences for stall, flush and mid-cycle reset.
module tb_alu_operand_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             stall, flush;
    logic             id_valid;
    logic [WIDTH-1:0] id_rd1, id_rd2;
    logic [4:0]       id_rs, id_rt;
    logic [15:0]      id_imm;
    logic             id_alu_src;
    logic [2:0]       id_alu_control;
    logic             id_reg_write;
    logic [4:0]       id_write_reg;
    logic             mem_reg_write;
    logic [4:0]       mem_write_reg;
    logic [WIDTH-1:0] mem_alu_result;
    logic             wb_reg_write;
    logic [4:0]       wb_write_reg;
    logic [WIDTH-1:0] wb_result;
    logic             ex_valid;
    logic [WIDTH-1:0] srca, srcb, ex_write_data;
    logic [2:0]       alu_control;
    logic             ex_reg_write;
    logic [4:0]       ex_write_reg;

    int n_applied = 0;
    int n_miss    = 0;

    alu_operand_stage #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rd1         (id_rd1),
        .id_rd2         (id_rd2),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_imm         (id_imm),
        .id_alu_src     (id_alu_src),
        .id_alu_control (id_alu_control),
        .id_reg_write   (id_reg_write),
        .id_write_reg   (id_write_reg),
        .mem_reg_write  (mem_reg_write),
        .mem_write_reg  (mem_write_reg),
        .mem_alu_result (mem_alu_result),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_result      (wb_result),
        .ex_valid       (ex_valid),
        .srca           (srca),
        .srcb           (srcb),
        .alu_control    (alu_control),
        .ex_write_data  (ex_write_data),
        .ex_reg_write   (ex_reg_write),
        .ex_write_reg   (ex_write_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2;
        logic [15:0] imm;
        logic        alu_src;
        logic [2:0]  ctl;
        logic        valid, rw;
        logic [4:0]  wr;
        logic        mem_rw;
        logic [4:0]  mem_wr;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_wr;
        logic [31:0] wb_res;
        logic [31:0] exp_srca, exp_srcb, exp_wd;
        logic        exp_valid, exp_rw;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [15:0] imm, input logic alu_src,
                            input logic [2:0] ctl, input logic valid,
                            input logic rw, input logic [4:0] wr);
        id_rs = rs; id_rt = rt; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_alu_src = alu_src; id_alu_control = ctl; id_valid = valid;
        id_reg_write = rw; id_write_reg = wr;
    endtask

    task automatic drive_fwd(input logic mrw, input logic [4:0] mwr, input logic [31:0] mres,
                             input logic wrw, input logic [4:0] wwr, input logic [31:0] wres);
        mem_reg_write = mrw; mem_write_reg = mwr; mem_alu_result = mres;
        wb_reg_write = wrw; wb_write_reg = wwr; wb_result = wres;
    endtask

    initial begin
        //            rs  rt  rd1     rd2     imm       src ctl     v  rw wr   mrw mwr mres         wrw wwr wres        srca         srcb         wd           ev erw
        vecs[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 16'h0000, 1'b0, 3'b010, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 32'd7, 1'b1, 1'b1};
        vecs[1] = '{5'd1, 5'd2, 32'd5, 32'd9, 16'hFFFC, 1'b1, 3'b010, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'hFFFFFFFC, 32'd9, 1'b1, 1'b1};
        vecs[2] = '{5'd1, 5'd2, 32'd5, 32'd9, 16'h0010, 1'b1, 3'b110, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'h00000010, 32'd9, 1'b1, 1'b0};
        vecs[3] = '{5'd3, 5'd2, 32'd1, 32'd2, 16'h0000, 1'b0, 3'b010, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'd2, 32'd2, 1'b1, 1'b1};
        vecs[4] = '{5'd3, 5'd2, 32'd1, 32'd2, 16'h0000, 1'b0, 3'b010, 1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB, 32'd2, 32'd2, 1'b1, 1'b1};
        vecs[5] = '{5'd0, 5'd2, 32'd0, 32'd2, 16'h0000, 1'b0, 3'b010, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 32'd0, 32'd2, 32'd2, 1'b1, 1'b1};
        vecs[6] = '{5'd1, 5'd4, 32'd6, 32'd3, 16'h8000, 1'b0, 3'b110, 1'b1, 1'b1, 5'd6, 1'b1, 5'd5, 32'h99, 1'b1, 5'd4, 32'h55, 32'd6, 32'h55, 32'h55, 1'b1, 1'b1};
        vecs[7] = '{5'd1, 5'd2, 32'd8, 32'd9, 16'h0000, 1'b0, 3'b110, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd8, 32'd9, 32'd9, 1'b0, 1'b0};
        vecs[8] = '{5'd1, 5'd0, 32'd4, 32'h77, 16'h0000, 1'b0, 3'b010, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'd4, 32'h77, 32'h77, 1'b1, 1'b1};

        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id(5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0);
        drive_fwd(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
        #12;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("rst_ex_write_reg", {27'd0, ex_write_reg}, 32'd0);
        check("rst_alu_control", {29'd0, alu_control}, 32'd2);
        check("rst_srca", srca, 32'd0);
        check("rst_srcb", srcb, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_id(vecs[i].rs, vecs[i].rt, vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
                     vecs[i].alu_src, vecs[i].ctl, vecs[i].valid, vecs[i].rw, vecs[i].wr);
            drive_fwd(vecs[i].mem_rw, vecs[i].mem_wr, vecs[i].mem_res,
                      vecs[i].wb_rw, vecs[i].wb_wr, vecs[i].wb_res);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_srca", i), srca, vecs[i].exp_srca);
            check($sformatf("v%0d_srcb", i), srcb, vecs[i].exp_srcb);
            check($sformatf("v%0d_write_data", i), ex_write_data, vecs[i].exp_wd);
            check($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_ex_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].exp_rw});
            check($sformatf("v%0d_ex_write_reg", i), {27'd0, ex_write_reg}, {27'd0, vecs[i].wr});
            check($sformatf("v%0d_alu_control", i), {29'd0, alu_control}, {29'd0, vecs[i].ctl});
        end

        // Instruction A, then stall two edges while B sits on the id_* inputs.
        @(negedge clk);
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_id(5'd6, 5'd7, 32'd11, 32'd22, 16'h0000, 1'b0, 3'b110, 1'b1, 1'b1, 5'd9);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        drive_id(5'd1, 5'd2, 32'd99, 32'd98, 16'h1234, 1'b1, 3'b010, 1'b0, 1'b0, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        check("stall_srca", srca, 32'd11);
        check("stall_srcb", srcb, 32'd22);
        check("stall_alu_control", {29'd0, alu_control}, 32'd6);
        check("stall_ex_write_reg", {27'd0, ex_write_reg}, 32'd9);
        check("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
        // Held operands still follow forwarding inputs.
        drive_fwd(1'b1, 5'd6, 32'hCC, 1'b1, 5'd7, 32'hDD);
        #1;
        check("stall_fwd_srca", srca, 32'hCC);
        check("stall_fwd_srcb", srcb, 32'hDD);

        // Flush beats stall.
        @(negedge clk);
        flush = 1'b1;
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("flush_alu_control", {29'd0, alu_control}, 32'd2);
        check("flush_ex_write_reg", {27'd0, ex_write_reg}, 32'd0);
        check("flush_srca", srca, 32'd0);
        check("flush_srcb", srcb, 32'd0);

        // Reload A, stall, then reset between edges.
        @(negedge clk);
        stall = 1'b0;
        drive_id(5'd6, 5'd7, 32'd11, 32'd22, 16'h0000, 1'b0, 3'b110, 1'b1, 1'b1, 5'd9);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        drive_fwd(1'b1, 5'd0, 32'h5A5A, 1'b1, 5'd0, 32'hA5A5);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("midrst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("midrst_ex_write_reg", {27'd0, ex_write_reg}, 32'd0);
        check("midrst_alu_control", {29'd0, alu_control}, 32'd2);
        check("midrst_srca", srca, 32'd0);
        check("midrst_srcb", srcb, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("postrst_srca", srca, 32'd11);
        check("postrst_ex_valid", {31'd0, ex_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of operands and results.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  hold all stage registers.
REQ-005 flush  in  1  load a bubble into the stage.
REQ-006 id_valid  in  1  decode-stage instruction valid.
REQ-007 id_rd1 / id_rd2  in  WIDTH  register-file read data for rs / rt.
REQ-008 id_rs / id_rt  in  5  source register numbers.
REQ-009 id_imm  in  16  instruction immediate.
REQ-010 id_alu_src  in  1  1 = srcb from sign-extended immediate, 0 = from rt.
REQ-011 id_alu_control  in  3  ALU operation code.
REQ-012 id_reg_write / id_write_reg  in  1 / 5  destination write enable / register number.
REQ-013 mem_reg_write / mem_write_reg / mem_alu_result  in  1 / 5 / WIDTH  memory-stage writeback info.
REQ-014 wb_reg_write / wb_write_reg / wb_result  in  1 / 5 / WIDTH  writeback-stage info.
REQ-015 ex_valid  out  1  execute-stage instruction valid.
REQ-016 srca / srcb  out  WIDTH  ALU operands.
REQ-017 alu_control  out  3  ALU operation code.
REQ-018 ex_write_data  out  WIDTH  forwarded rt value for stores.
REQ-019 ex_reg_write / ex_write_reg  out  1 / 5  destination passed downstream.

Function
REQ-020 Each rising edge with flush=0, stall=0, the block SHALL register all id_* inputs; outputs reflect them one cycle later.
REQ-021 stall=1, flush=0 SHALL hold every stage register unchanged.
REQ-022 flush=1 SHALL load a bubble regardless of stall: ex_valid=0, ex_reg_write=0, alu_control=3'b010, all other fields 0.
REQ-023 Forwarding SHALL be combinational from the registered rs/rt against the current mem_*/wb_* inputs.
REQ-024 Operand A select: mem_alu_result if mem_reg_write and mem_write_reg==rs and rs!=0; else wb_result if wb_reg_write and wb_write_reg==rs and rs!=0; else registered rd1.
REQ-025 Operand B forwarding SHALL use the REQ-024 rule with rt and rd2, result driven on ex_write_data.
REQ-026 srcb SHALL equal sign-extended registered imm (bit 15 replicated to WIDTH) when alu_src=1, else ex_write_data.
REQ-027 Register 0 SHALL never be a forwarding match; the registered rd value passes through.
REQ-028 MEM match SHALL take priority over WB match when both hit the same register.
REQ-029 id_valid=0 SHALL register ex_valid=0 and ex_reg_write=0; other fields register normally.
REQ-030 Forwarding SHALL remain active during stall, so held operands track changing mem_*/wb_* inputs.

Reset
REQ-031 reset_n=0 SHALL immediately clear all registers: ex_valid=0, ex_reg_write=0, ex_write_reg=0, alu_control=3'b010, registered rd1/rd2/imm/rs/rt=0.
REQ-032 With rs=rt=0 after reset, srca=0 and srcb=0 regardless of mem_*/wb_* inputs.
REQ-033 Reset asserted mid-stall or mid-flush SHALL override both; first post-reset edge behaves per REQ-020..022.

Structure
REQ-034 tinymips_pkg SHALL hold ALU codes (ALU_ADD=3'b010, ALU_SUB=3'b110), the forward-select enum (FWD_REG, FWD_WB, FWD_MEM) and the bubble alu_control constant.
REQ-035 One sub-module, fwd_mux, SHALL implement REQ-024/027/028 and be instantiated twice (rs, rt).
REQ-036 srca, srcb and alu_control SHALL connect directly to the alu ports of the same names.

Verification
REQ-037 rd1=5, rd2=7, alu_src=0, no hazards, one edge -> srca=5, srcb=7, ex_valid=1.
REQ-038 imm=16'hFFFC, alu_src=1 -> srcb=32'hFFFFFFFC; imm=16'h0010 -> srcb=32'h00000010.
REQ-039 rs=3; mem_write_reg=3, mem_alu_result=32'hAA; wb_write_reg=3, wb_result=32'hBB; both reg_write=1 -> srca=32'hAA; drop mem_reg_write -> srca=32'hBB.
REQ-040 rs=0, mem_write_reg=0, mem_reg_write=1, mem_alu_result=32'h1234, rd1=0 -> srca=0.
REQ-041 Load instr A, stall=1 for 2 edges with new id_* -> outputs stay A; flush=1 with stall=1 -> ex_valid=0, ex_reg_write=0, alu_control=3'b010.
REQ-042 reset_n low between clock edges during stall -> all outputs at REQ-031 values before next edge.
